// File: rtl/division.sv
// Iterative restoring divider: one quotient bit per clock.
// Divide-by-zero resolves in a single cycle without entering RUN.
module division #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, nextState;

  logic [WIDTH-1:0] dividend, divisor;
  logic [WIDTH:0]   partial;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   pShift, pNext;
  logic [WIDTH-1:0] qNext;
  logic             fits, lastStep, accept, zeroDiv;

  always_comb begin
    pShift   = {partial[WIDTH-1:0], dividend[WIDTH-1]};
    fits     = pShift >= {1'b0, divisor};
    pNext    = fits ? pShift - {1'b0, divisor} : pShift;
    qNext    = {dividend[WIDTH-2:0], fits};
    lastStep = count == CntOne;
    accept   = start && (state == IDLE);
    zeroDiv  = B == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept && !zeroDiv) nextState = RUN;
      RUN:  if (lastStep)           nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = state == RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend  <= '0;
      divisor   <= '0;
      partial   <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        accept && zeroDiv: begin
          Quotient  <= '1;
          Remainder <= A;
          DivByZero <= 1'b1;
          done      <= 1'b1;
        end
        accept && !zeroDiv: begin
          dividend <= A;
          divisor  <= B;
          partial  <= '0;
          count    <= CntInit;
        end
        state == RUN: begin
          dividend <= qNext;
          partial  <= pNext;
          count    <= count - CntOne;
          if (lastStep) begin
            Quotient  <= qNext;
            Remainder <= pNext[WIDTH-1:0];
            DivByZero <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Directed and random checks for the iterative divider.
// Vectors carry hand-computed quotient, remainder and latency.
module tb_division;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         DivByZero, busy, done;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  division #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one start pulse; return edges from acceptance to done (-1 on timeout).
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    if (done) lat = 0;
    else begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (done) begin lat = i; break; end
      end
    end
  endtask

  initial begin
    int lat, seen;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{16'd0,     16'd0,     16'hFFFF, 16'd0, 1'b1, 0};
    vecs[1]  = '{16'd7,     16'd0,     16'hFFFF, 16'd7, 1'b1, 0};
    vecs[2]  = '{16'd5,     16'd2,     16'd2,    16'd1, 1'b0, 16};
    vecs[3]  = '{16'd18,    16'd3,     16'd6,    16'd0, 1'b0, 16};
    vecs[4]  = '{16'd18,    16'd4,     16'd4,    16'd2, 1'b0, 16};
    vecs[5]  = '{16'd18,    16'd5,     16'd3,    16'd3, 1'b0, 16};
    vecs[6]  = '{16'hFFFF,  16'd1,     16'hFFFF, 16'd0, 1'b0, 16};
    vecs[7]  = '{16'hFFFF,  16'hFFFF,  16'd1,    16'd0, 1'b0, 16};
    vecs[8]  = '{16'd3,     16'hFFFF,  16'd0,    16'd3, 1'b0, 16};
    vecs[9]  = '{16'd0,     16'd9,     16'd0,    16'd0, 1'b0, 16};
    vecs[10] = '{16'd1000,  16'd33,    16'd30,   16'd10, 1'b0, 16};
    vecs[11] = '{16'h8000,  16'd3,     16'd10922, 16'd2, 1'b0, 16};

    #12;
    check("reset Quotient", Quotient, 0);
    check("reset Remainder", Remainder, 0);
    check("reset DivByZero", DivByZero, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      runOp(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d Quotient", i), Quotient, vecs[i].q);
      check($sformatf("vec%0d Remainder", i), Remainder, vecs[i].r);
      check($sformatf("vec%0d DivByZero", i), DivByZero, vecs[i].dbz);
      check($sformatf("vec%0d busy", i), busy, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse width", i), done, 0);
      check($sformatf("vec%0d hold Quotient", i), Quotient, vecs[i].q);
    end

    // Reset mid-operation abandons the division.
    @(negedge clk);
    A = 16'd18; B = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset Quotient", Quotient, 0);
    check("midreset Remainder", Remainder, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midreset no done", seen, 0);
    runOp(16'd18, 16'd3, lat);
    check("post-reset latency", lat, 16);
    check("post-reset Quotient", Quotient, 6);
    check("post-reset Remainder", Remainder, 0);

    // Start while busy is ignored; then back-to-back start in the done cycle.
    @(negedge clk);
    A = 16'd18; B = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    A = 16'd100; B = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 5; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check("ignored-start latency", lat, 16);
    check("ignored-start Quotient", Quotient, 3);
    check("ignored-start Remainder", Remainder, 3);
    runOp(16'd100, 16'd7, lat);
    check("back-to-back latency", lat, 16);
    check("back-to-back Quotient", Quotient, 14);
    check("back-to-back Remainder", Remainder, 2);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 4 == 0) rb = W'($urandom_range(1, 15));
      if (rb == 0) rb = 16'd1;
      runOp(ra, rb, lat);
      check("rand latency", lat, 16);
      check("rand identity",
            longint'(Quotient) * longint'(rb) + longint'(Remainder),
            longint'(ra));
      check("rand rem<B", longint'(Remainder < rb), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/division.md
Name: division

Overview:
- Iterative unsigned integer divider for the ALU.
- Computes Quotient = A / B and Remainder = A % B using a restoring shift-subtract algorithm, one quotient bit per clock.
- Flags division by zero.
- Sits behind the ALU's multi-cycle operation path. The ALU issues a start pulse and waits for done.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; A and B are sampled when start=1 and busy=0.
- A  input  WIDTH  dividend, unsigned.
- B  input  WIDTH  divisor, unsigned.
- Quotient  output  WIDTH  registered quotient of the last completed operation.
- Remainder  output  WIDTH  registered remainder of the last completed operation.
- DivByZero  output  1  registered; 1 if the last completed operation had B=0.
- busy  output  1  1 while an iteration sequence is in progress.
- done  output  1  one-cycle pulse marking that result outputs were just updated.

Behaviour:
- Reset (rst_n=0, asynchronous): Quotient=0, Remainder=0, DivByZero=0, busy=0, done=0, iteration counter=0. Any in-flight operation is abandoned and produces no done.
- States: IDLE and RUN.
- IDLE, start=1, B!=0, on edge E0:
  - latch A into the dividend shift register and B into the divisor register;
  - clear the partial remainder;
  - counter=WIDTH; busy=1; go to RUN.
- IDLE, start=1, B=0, on edge E0:
  - Quotient = all ones, Remainder = A, DivByZero = 1, done = 1;
  - stay in IDLE; busy stays 0.
- RUN, each edge:
  - partial remainder P (WIDTH+1 bits) shifts left, taking the MSB of the dividend register;
  - if P >= divisor, P = P - divisor and quotient bit 1; else quotient bit 0;
  - the quotient bit is shifted into the dividend register LSB; counter decrements.
- Completion: on edge E_WIDTH (the WIDTH-th edge after E0):
  - Quotient = final quotient, Remainder = P[WIDTH-1:0], DivByZero = 0;
  - done = 1, busy = 0; go to IDLE.
- Latency: done is high during the cycle after E_WIDTH for normal operations, and the cycle after E0 for divide-by-zero.
- done is high for exactly one cycle, then returns to 0 unless another completion occurs on that edge.
- start while busy=1 is ignored. Operands are not re-sampled; changes to A and B during RUN have no effect.
- A new start is accepted on the edge where done is asserted only if busy=0 (i.e. the following cycle). Back-to-back throughput is one operation per WIDTH+1 cycles.
- Result outputs hold their values between completions.
- Arithmetic is unsigned. For B!=0, the invariant A = Quotient*B + Remainder and Remainder < B always holds.
- A=0 with B!=0 gives Quotient=0, Remainder=0.

Test Plan:
- Reset mid-operation: start 18/3, assert rst_n=0 after 5 cycles -> all outputs 0 immediately; no done pulse follows; next start 18/3 completes normally.
- Divide by zero: A=0,B=0 -> Q=16'hFFFF, R=0, DivByZero=1, done one cycle after start. Then A=7,B=0 -> Q=16'hFFFF, R=7, DivByZero=1.
- Small values: 5/2 -> Q=2,R=1. 18/3 -> Q=6,R=0. 18/4 -> Q=4,R=2. 18/5 -> Q=3,R=3. In each case DivByZero=0 and done pulses exactly 16 cycles after start is accepted.
- Extremes: 16'hFFFF/1 -> Q=16'hFFFF,R=0. 16'hFFFF/16'hFFFF -> Q=1,R=0. 3/16'hFFFF -> Q=0,R=3. 0/9 -> Q=0,R=0.
- Handshake: pulse start again while busy with A=100,B=7 -> ignored, first result unchanged. Then issue A=100,B=7 in the cycle after done -> Q=14,R=2.
- Random: 1000 random A, B (B!=0) -> A == Q*B+R and R<B, checked each time done=1.
